// File: rtl/mem_bus_ctrl_pkg.sv
// Shared load/store unit definitions: MEM op bus width, op encodings and
// the helpers that map an op onto bus lanes.
package mem_bus_ctrl_pkg;

    localparam int MEM_OP_W = 3;
    typedef logic [MEM_OP_W-1:0] mem_op_t;

    localparam mem_op_t OP_LB  = 3'b000;
    localparam mem_op_t OP_LBU = 3'b001;
    localparam mem_op_t OP_LH  = 3'b010;
    localparam mem_op_t OP_LHU = 3'b011;
    localparam mem_op_t OP_LW  = 3'b100;
    localparam mem_op_t OP_SB  = 3'b101;
    localparam mem_op_t OP_SH  = 3'b110;
    localparam mem_op_t OP_SW  = 3'b111;

    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} mem_size_t;

    function automatic mem_size_t op_size(input mem_op_t op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: return SZ_HALF;
            default:              return SZ_WORD;
        endcase
    endfunction

    function automatic logic op_is_store(input mem_op_t op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic op_misaligned(input mem_op_t op, input logic [1:0] addr_lo);
        case (op_size(op))
            SZ_HALF: return addr_lo[0];
            SZ_WORD: return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    // Big-endian lanes: sel bit 3 enables bits [31:24] (byte 0).
    function automatic logic [3:0] lane_sel(input mem_op_t op, input logic [1:0] addr_lo);
        case (op_size(op))
            SZ_BYTE: return 4'b1000 >> addr_lo;
            SZ_HALF: return addr_lo[1] ? 4'b0011 : 4'b1100;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input mem_op_t op, input logic [31:0] wd);
        case (op_size(op))
            SZ_BYTE: return {4{wd[7:0]}};
            SZ_HALF: return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Picks the addressed byte/half out of a big-endian bus word and
// sign- or zero-extends it according to the load op.
module mem_load_align
    import mem_bus_ctrl_pkg::*;
(
    input  mem_op_t     op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    output logic [31:0] result
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = word[31:24];
        case (addr_lo)
            2'd0:    byte_v = word[31:24];
            2'd1:    byte_v = word[23:16];
            2'd2:    byte_v = word[15:8];
            default: byte_v = word[7:0];
        endcase
        half_v = addr_lo[1] ? word[15:0] : word[31:16];

        result = word;
        case (op)
            OP_LB:   result = {{24{byte_v[7]}}, byte_v};
            OP_LBU:  result = {24'h0, byte_v};
            OP_LH:   result = {{16{half_v[15]}}, half_v};
            OP_LHU:  result = {16'h0, half_v};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// MEM-stage data-bus controller: latches one load/store, runs a single bus
// access with timeout, and returns aligned load data with a done pulse.
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o,
    output logic        err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic        bus_err_i,
    input  logic [31:0] bus_rdata_i
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t      state, state_nxt;
    mem_op_t     op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        misalign_q;
    logic        err_q;
    logic [15:0] cnt;
    logic [31:0] load_word;
    logic        tmo;
    logic        in_access;
    logic        in_resp;

    assign tmo = (cnt == 16'(TIMEOUT - 1));

    mem_load_align u_align (
        .op      (op_q),
        .addr_lo (addr_q[1:0]),
        .word    (bus_rdata_i),
        .result  (load_word)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:
                if (req_i)
                    state_nxt = op_misaligned(op_i, addr_i[1:0]) ? S_RESP : S_ACCESS;
            S_ACCESS:
                if (bus_ack_i || bus_err_i || tmo) state_nxt = S_RESP;
            S_RESP:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Request latch, timeout counter and response capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= OP_LB;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
            err_q      <= 1'b0;
            cnt        <= '0;
        end else begin
            case (state)
                S_IDLE: if (req_i) begin
                    op_q       <= op_i;
                    addr_q     <= addr_i;
                    wdata_q    <= wdata_i;
                    rdata_q    <= '0;
                    err_q      <= 1'b0;
                    misalign_q <= op_misaligned(op_i, addr_i[1:0]);
                    cnt        <= '0;
                end
                S_ACCESS: begin
                    cnt <= cnt + 16'd1;
                    // Error beats a simultaneous ack; ack on the last cycle beats timeout.
                    if (bus_err_i)
                        err_q <= 1'b1;
                    else if (bus_ack_i)
                        rdata_q <= op_is_store(op_q) ? 32'h0 : load_word;
                    else if (tmo)
                        err_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Outputs are forced low while rst is asserted, whatever the state.
    assign in_access = !rst && (state == S_ACCESS);
    assign in_resp   = !rst && (state == S_RESP);

    assign stall_o     = !rst && ((state == S_IDLE && req_i) || state == S_ACCESS);
    assign bus_req_o   = in_access;
    assign bus_we_o    = in_access && op_is_store(op_q);
    assign bus_addr_o  = in_access ? {addr_q[31:2], 2'b00} : 32'h0;
    assign bus_sel_o   = in_access ? lane_sel(op_q, addr_q[1:0]) : 4'h0;
    assign bus_wdata_o = in_access ? store_data(op_q, wdata_q) : 32'h0;

    assign done_o     = in_resp;
    assign rdata_o    = in_resp ? rdata_q : 32'h0;
    assign misalign_o = in_resp && misalign_q;
    assign err_o      = in_resp && err_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl with hand-computed expected values.
module tb_mem_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i;
    logic [2:0]  op_i;
    logic [31:0] addr_i, wdata_i;
    logic        stall_o, done_o, misalign_o, err_o;
    logic [31:0] rdata_o;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_sel_o;
    logic        bus_ack_i, bus_err_i;
    logic [31:0] bus_rdata_i;

    int n_vec = 0;
    int n_bad = 0;

    // Snapshots taken during the first ACCESS cycle and the RESP cycle.
    logic        a_req, a_we, a_stall, a_stall_late;
    logic [31:0] a_addr, a_wdata;
    logic [3:0]  a_sel;
    logic        r_done, r_err, r_mis, r_stall, r_bus_req, i_done;
    logic [31:0] r_rdata;
    int          k;

    localparam logic [2:0] LB = 3'b000, LBU = 3'b001, LH = 3'b010, LHU = 3'b011,
                           LW = 3'b100, SB = 3'b101, SH = 3'b110, SW = 3'b111;

    always #5 clk = ~clk;

    mem_bus_ctrl #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .op_i(op_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .stall_o(stall_o), .done_o(done_o), .rdata_o(rdata_o),
        .misalign_o(misalign_o), .err_o(err_o), .bus_req_o(bus_req_o),
        .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_sel_o(bus_sel_o),
        .bus_wdata_o(bus_wdata_o), .bus_ack_i(bus_ack_i), .bus_err_i(bus_err_i),
        .bus_rdata_i(bus_rdata_i)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One access: accept, nwait idle ACCESS cycles, then a response cycle,
    // then the return to IDLE. Request inputs are scrambled after accept.
    task automatic xfer(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input int nwait, input logic [31:0] brd, input logic back, input logic berr);
        req_i = 1'b1; op_i = op; addr_i = addr; wdata_i = wd;
        step();
        req_i = 1'b0; op_i = ~op; addr_i = ~addr; wdata_i = ~wd;
        a_req = bus_req_o; a_we = bus_we_o; a_addr = bus_addr_o;
        a_sel = bus_sel_o; a_wdata = bus_wdata_o; a_stall = stall_o;
        repeat (nwait) step();
        a_stall_late = stall_o;
        bus_ack_i = back; bus_err_i = berr; bus_rdata_i = brd;
        step();
        bus_ack_i = 1'b0; bus_err_i = 1'b0; bus_rdata_i = 32'h0;
        r_done = done_o; r_err = err_o; r_mis = misalign_o; r_rdata = rdata_o;
        r_stall = stall_o; r_bus_req = bus_req_o;
        step();
        i_done = done_o;
    endtask

    initial begin
        rst = 1'b1; req_i = 1'b1; op_i = LW; addr_i = 32'h100; wdata_i = 32'h0;
        bus_ack_i = 1'b0; bus_err_i = 1'b0; bus_rdata_i = 32'h0;
        step(); step();
        check("rst_stall", {31'h0, stall_o}, 32'h0);
        check("rst_busreq", {31'h0, bus_req_o}, 32'h0);
        check("rst_outs", {bus_we_o, done_o, misalign_o, err_o, bus_sel_o}, 32'h0);
        check("rst_addr", bus_addr_o | bus_wdata_o | rdata_o, 32'h0);
        rst = 1'b0; req_i = 1'b0;
        step();
        check("idle_stall", {31'h0, stall_o}, 32'h0);
        req_i = 1'b1; #1;
        check("idle_req_stall", {31'h0, stall_o}, 32'h1);
        req_i = 1'b0;

        // LW, ack on 2nd ACCESS cycle
        xfer(LW, 32'h0000_0100, 32'h0, 1, 32'hDEAD_BEEF, 1'b1, 1'b0);
        check("lw_req", {31'h0, a_req}, 32'h1);
        check("lw_sel", {28'h0, a_sel}, 32'hF);
        check("lw_addr", a_addr, 32'h100);
        check("lw_we", {31'h0, a_we}, 32'h0);
        check("lw_stall", {30'h0, a_stall, a_stall_late}, 32'h3);
        check("lw_done", {31'h0, r_done}, 32'h1);
        check("lw_rdata", r_rdata, 32'hDEAD_BEEF);
        check("lw_resp_stall", {30'h0, r_stall, r_bus_req}, 32'h0);
        check("lw_done_once", {31'h0, i_done}, 32'h0);

        // Byte loads, lane 3
        xfer(LB, 32'h0000_0103, 32'h0, 0, 32'h1234_56F0, 1'b1, 1'b0);
        check("lb_sel", {28'h0, a_sel}, 32'h1);
        check("lb_rdata", r_rdata, 32'hFFFF_FFF0);
        xfer(LBU, 32'h0000_0103, 32'h0, 0, 32'h1234_56F0, 1'b1, 1'b0);
        check("lbu_rdata", r_rdata, 32'h0000_00F0);

        // Half loads, lower half
        xfer(LH, 32'h0000_0002, 32'h0, 0, 32'h1234_ABCD, 1'b1, 1'b0);
        check("lh_rdata", r_rdata, 32'hFFFF_ABCD);
        xfer(LHU, 32'h0000_0000, 32'h0, 0, 32'h8765_ABCD, 1'b1, 1'b0);
        check("lhu_sel", {28'h0, a_sel}, 32'hC);
        check("lhu_rdata", r_rdata, 32'h0000_8765);

        // SH
        xfer(SH, 32'h0000_0202, 32'h0000_ABCD, 0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        check("sh_addr", a_addr, 32'h200);
        check("sh_sel", {28'h0, a_sel}, 32'h3);
        check("sh_wdata", a_wdata, 32'hABCD_ABCD);
        check("sh_we", {31'h0, a_we}, 32'h1);
        check("sh_done", {31'h0, r_done}, 32'h1);
        check("sh_rdata", r_rdata, 32'h0);

        // SB lane 1
        xfer(SB, 32'h0000_0011, 32'h1234_565A, 0, 32'h0, 1'b1, 1'b0);
        check("sb_sel", {28'h0, a_sel}, 32'h4);
        check("sb_wdata", a_wdata, 32'h5A5A_5A5A);

        // ack and err together: error wins
        xfer(LW, 32'h0000_0040, 32'h0, 0, 32'h1111_1111, 1'b1, 1'b1);
        check("accerr_err", {31'h0, r_err}, 32'h1);
        check("accerr_rdata", r_rdata, 32'h0);

        // Misaligned LW
        req_i = 1'b1; op_i = LW; addr_i = 32'h0000_0101;
        #1;
        check("mis_busreq0", {31'h0, bus_req_o}, 32'h0);
        step();
        req_i = 1'b0;
        check("mis_done", {31'h0, done_o}, 32'h1);
        check("mis_flag", {31'h0, misalign_o}, 32'h1);
        check("mis_busreq1", {30'h0, bus_req_o, err_o}, 32'h0);
        check("mis_rdata", rdata_o, 32'h0);
        step();
        check("mis_idle", {30'h0, done_o, bus_req_o}, 32'h0);

        // Timeout after 16 ACCESS cycles, late ack ignored
        req_i = 1'b1; op_i = LW; addr_i = 32'h0000_0080;
        step();
        req_i = 1'b0;
        k = 0;
        while (!done_o && k < 40) begin
            step();
            k++;
        end
        check("tmo_cycles", k, 16);
        check("tmo_err", {31'h0, err_o}, 32'h1);
        check("tmo_rdata", rdata_o, 32'h0);
        bus_ack_i = 1'b1; bus_rdata_i = 32'hCAFE_F00D;
        step();
        check("late_ack1", {30'h0, done_o, bus_req_o}, 32'h0);
        step();
        check("late_ack2", {29'h0, done_o, bus_req_o, stall_o}, 32'h0);
        bus_ack_i = 1'b0; bus_rdata_i = 32'h0;

        // Reset in 3rd ACCESS cycle
        req_i = 1'b1; op_i = SW; addr_i = 32'h0000_0300; wdata_i = 32'h5555_AAAA;
        step();
        req_i = 1'b0;
        step(); step();
        check("rstmid_busreq_pre", {31'h0, bus_req_o}, 32'h1);
        rst = 1'b1;
        step();
        check("rstmid_busreq", {31'h0, bus_req_o}, 32'h0);
        check("rstmid_stall", {31'h0, stall_o}, 32'h0);
        check("rstmid_done", {31'h0, done_o}, 32'h0);
        rst = 1'b0;
        step();
        check("rstmid_idle", {30'h0, done_o, bus_req_o}, 32'h0);

        xfer(SW, 32'h0000_0300, 32'h1122_3344, 0, 32'h0, 1'b1, 1'b0);
        check("sw_sel", {28'h0, a_sel}, 32'hF);
        check("sw_wdata", a_wdata, 32'h1122_3344);
        check("sw_we", {31'h0, a_we}, 32'h1);
        check("sw_done", {30'h0, r_done, r_err}, 32'h2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_bus_ctrl.md
MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64: maximum cycles in ACCESS before an access is aborted; legal range 2..65535.
REQ-002 SHALL have port clk  in  1  rising-edge clock.
REQ-003 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-004 SHALL have port req_i  in  1  MEM stage holds a valid load/store.
REQ-005 SHALL have port op_i  in  3  operation: LB=000 LBU=001 LH=010 LHU=011 LW=100 SB=101 SH=110 SW=111.
REQ-006 SHALL have port addr_i  in  32  byte address.
REQ-007 SHALL have port wdata_i  in  32  store data, right-justified.
REQ-008 SHALL have port stall_o  out  1  freeze IF..MEM pipeline registers.
REQ-009 SHALL have port done_o  out  1  one-cycle completion pulse.
REQ-010 SHALL have port rdata_o  out  32  aligned, extended load data; valid with done_o.
REQ-011 SHALL have port misalign_o  out  1  alignment fault; valid with done_o.
REQ-012 SHALL have port err_o  out  1  bus error or timeout; valid with done_o.
REQ-013 SHALL have ports bus_req_o out 1, bus_we_o out 1, bus_addr_o out 32, bus_sel_o out 4, bus_wdata_o out 32: data-bus request side.
REQ-014 SHALL have ports bus_ack_i in 1, bus_err_i in 1, bus_rdata_i in 32: data-bus response side.

Function
REQ-015 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-016 IDLE, req_i=1, aligned: SHALL latch op, addr and wdata, then go to ACCESS.
REQ-017 IDLE, req_i=1, misaligned: SHALL go to RESP with misalign flag set and SHALL NOT assert bus_req_o.
REQ-018 Misaligned SHALL mean: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
REQ-019 ACCESS: SHALL hold bus_req_o=1 and all bus_* outputs stable from registers.
REQ-020 ACCESS: SHALL go to RESP on bus_ack_i, bus_err_i, or the TIMEOUT-th ACCESS cycle.
REQ-021 ACCESS: if bus_ack_i and bus_err_i are both 1 in the same cycle, error SHALL win.
REQ-022 RESP: SHALL drive done_o=1 for exactly one cycle, then go to IDLE unconditionally.
REQ-023 stall_o SHALL be 1 in (IDLE & req_i) and in ACCESS, and 0 in RESP.
REQ-024 Minimum latency SHALL be 3 cycles from accept to the end of RESP (ack in first ACCESS cycle).
REQ-025 bus_addr_o SHALL be {addr[31:2],2'b00}.
REQ-026 Byte lanes SHALL be big-endian: byte 0 is bits [31:24].
REQ-027 bus_sel_o: byte ops SHALL drive 4'b1000>>addr[1:0]; half ops 1100 (addr[1]=0) or 0011 (addr[1]=1); word ops 1111.
REQ-028 bus_wdata_o: SB SHALL drive {4{wdata[7:0]}}; SH {2{wdata[15:0]}}; SW wdata.
REQ-029 bus_we_o SHALL be 1 for SB/SH/SW only.
REQ-030 Loads: the selected lane SHALL be captured from bus_rdata_i on ack; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-031 rdata_o SHALL be 0 for stores, errors and misalignment.
REQ-032 A change or drop of req_i during ACCESS SHALL be ignored; the access completes.
REQ-033 bus_ack_i/bus_err_i outside ACCESS, including a late ack after timeout, SHALL be ignored.
REQ-034 The timeout counter SHALL clear on entry to ACCESS.

Reset
REQ-035 rst=1 SHALL force IDLE and clear the counter and latched request, from any state including mid-ACCESS.
REQ-036 During reset, all outputs SHALL be 0, and bus_req_o SHALL be 0 in the cycle after rst is sampled.

Structure
REQ-037 MemOpBus width and the op encodings (LB..SW) SHALL live in the shared defines file.
REQ-038 FSM state encodings SHALL be local to the module.
REQ-039 Lane select and extension SHALL be the combinational sub-module mem_load_align (inputs op, addr[1:0], bus word; output 32-bit result).

Verification
REQ-040 LW 0x00000100, ack on 2nd ACCESS cycle with rdata 0xDEADBEEF -> sel 1111, addr 0x100, we=0, rdata_o 0xDEADBEEF with done_o, stall_o high until RESP.
REQ-041 LB 0x00000103, rdata 0x123456F0 -> sel 0001, rdata_o 0xFFFFFFF0; same with LBU -> 0x000000F0.
REQ-042 SH 0x00000202, wdata 0x0000ABCD -> bus_addr 0x200, sel 0011, bus_wdata 0xABCDABCD, we=1, done_o, rdata_o 0.
REQ-043 LW 0x00000101 -> misalign_o=1 and done_o one cycle later, bus_req_o never asserted.
REQ-044 TIMEOUT=16, no ack -> err_o=1 with done_o after 16 ACCESS cycles; a subsequent ack is ignored.
REQ-045 rst pulsed in the 3rd ACCESS cycle -> bus_req_o=0 and stall_o=0 the next cycle, no done_o; a new SW then completes normally.
